// File: rtl/spike_readout.sv
`default_nettype none
// ============================================================================
// Module   : spike_readout
// Purpose  : Counts spikes per neuron over an enabled-cycle window, scans for
//            the winner and offers it on a valid/ready handshake. Lateral
//            inhibition is built only with SPIKE_READOUT_LATERAL_INH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spike_readout #(
  parameter int N_NEURON = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 8,
  parameter int T_WINDOW = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [N_NEURON-1:0] spikes,
  input  logic                result_ready,
  output logic                busy,
  output logic                result_valid,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [CNT_W-1:0]    winner_cnt,
  output logic                tie,
  output logic                inh
);

  localparam logic [1:0]       c_idle     = 2'd0;
  localparam logic [1:0]       c_collect  = 2'd1;
  localparam logic [1:0]       c_scan     = 2'd2;
  localparam logic [1:0]       c_done     = 2'd3;
  localparam logic [15:0]      c_win_last = 16'(T_WINDOW - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_NEURON - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt [N_NEURON];
  logic [15:0]      r_win;
  logic [IDX_W-1:0] r_scan_idx, r_max_idx, w_max_idx, r_winner_idx;
  logic [CNT_W-1:0] r_max_cnt, w_max_cnt, w_cur, r_winner_cnt;
  logic             r_tie_run, w_tie_run, r_tie;
  logic             w_start_win, w_close, w_scan_last, w_busy, w_valid;

  assign w_start_win = (r_state == c_idle) && start;
  assign w_close     = (r_state == c_collect) && en && (r_win == c_win_last);
  assign w_scan_last = (r_state == c_scan) && (r_scan_idx == c_idx_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:    if (start)        w_next = c_collect;
      c_collect: if (w_close)      w_next = c_scan;
      c_scan:    if (w_scan_last)  w_next = c_done;
      c_done:    if (result_ready) w_next = c_idle;
      default:                     w_next = c_idle;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != c_idle);
    w_valid = (r_state == c_done);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_NEURON; i++) begin
      if (rst || w_start_win)
        r_cnt[i] <= '0;
      else if ((r_state == c_collect) && en && spikes[i] && (r_cnt[i] != c_cnt_max))
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_win)
      r_win <= '0;
    else if ((r_state == c_collect) && en)
      r_win <= r_win + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != c_scan)) r_scan_idx <= '0;
    else                            r_scan_idx <= r_scan_idx + IDX_W'(1);
  end

  // Index 0 seeds the running max; later neurons displace it only when strictly greater.
  assign w_cur = r_cnt[r_scan_idx];
  always_comb begin
    w_max_idx = r_max_idx;
    w_max_cnt = r_max_cnt;
    w_tie_run = r_tie_run;
    if (r_scan_idx == '0) begin
      w_max_idx = '0;
      w_max_cnt = w_cur;
      w_tie_run = 1'b0;
    end else if (w_cur > r_max_cnt) begin
      w_max_idx = r_scan_idx;
      w_max_cnt = w_cur;
      w_tie_run = 1'b0;
    end else if ((w_cur == r_max_cnt) && (w_cur != '0)) begin
      w_tie_run = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_idx <= '0;
      r_max_cnt <= '0;
      r_tie_run <= 1'b0;
    end else if (r_state == c_scan) begin
      r_max_idx <= w_max_idx;
      r_max_cnt <= w_max_cnt;
      r_tie_run <= w_tie_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner_idx <= '0;
      r_winner_cnt <= '0;
      r_tie        <= 1'b0;
    end else if (w_scan_last) begin
      r_winner_idx <= w_max_idx;
      r_winner_cnt <= w_max_cnt;
      r_tie        <= w_tie_run;
    end
  end

`ifdef SPIKE_READOUT_LATERAL_INH_EN
  // No pulse after the closing cycle: the array is no longer being observed.
  logic r_inh;
  always_ff @(posedge clk) begin
    if (rst) r_inh <= 1'b0;
    else     r_inh <= (r_state == c_collect) && en && (|spikes) && !w_close;
  end
  assign inh = r_inh;
`else
  assign inh = 1'b0;
`endif

  assign busy         = w_busy;
  assign result_valid = w_valid;
  assign winner_idx   = r_winner_idx;
  assign winner_cnt   = r_winner_cnt;
  assign tie          = r_tie;

endmodule
`default_nettype wire

// File: tb/tb_spike_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_readout
// Purpose  : Table, hand-written and random windows checked against a
//            count/argmax reference model of the readout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_readout;

  localparam int N  = 4;
  localparam int TW = 10;
  localparam int CW = 3;
`ifdef SPIKE_READOUT_LATERAL_INH_EN
  localparam bit INH_ON = 1'b1;
`else
  localparam bit INH_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, start, result_ready;
  logic [N-1:0] spikes;
  logic         busy, result_valid, tie, inh;
  logic [1:0]   winner_idx;
  logic [CW-1:0] winner_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] sp_q[$];
  bit           en_q[$];

  typedef struct {
    int c0, c1, c2, c3;
    int gap, hold;
    int e_idx, e_cnt, e_tie;
  } vec_t;
  vec_t vecs[6];

  spike_readout #(.N_NEURON(N), .IDX_W(2), .CNT_W(CW), .T_WINDOW(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .spikes(spikes),
    .result_ready(result_ready), .busy(busy), .result_valid(result_valid),
    .winner_idx(winner_idx), .winner_cnt(winner_cnt), .tie(tie), .inh(inh)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  // Neuron j spikes on its first c_j enabled cycles; gap en-low cycles (all spikes high) precede enabled cycle 5.
  task automatic build_counts(input int c0, input int c1, input int c2, input int c3, input int gap);
    logic [N-1:0] s;
    sp_q.delete(); en_q.delete();
    for (int i = 0; i < TW; i++) begin
      if (i == 5) for (int g = 0; g < gap; g++) begin sp_q.push_back('1); en_q.push_back(1'b0); end
      s = {1'(i < c3), 1'(i < c2), 1'(i < c1), 1'(i < c0)};
      sp_q.push_back(s); en_q.push_back(1'b1);
    end
  endtask

  task automatic build_random();
    int dens[N];
    logic [N-1:0] s;
    sp_q.delete(); en_q.delete();
    foreach (dens[j]) dens[j] = int'($urandom_range(0, 10));
    for (int i = 0; i < TW; i++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) begin sp_q.push_back(N'($urandom)); en_q.push_back(1'b0); end
      for (int j = 0; j < N; j++) s[j] = (int'($urandom_range(0, 9)) < dens[j]);
      sp_q.push_back(s); en_q.push_back(1'b1);
    end
  endtask

  task automatic model(output int idx, output int cnt, output int t);
    int c[N];
    int best, nbest;
    foreach (c[j]) c[j] = 0;
    foreach (sp_q[i]) if (en_q[i]) for (int j = 0; j < N; j++) c[j] += int'(sp_q[i][j]);
    best = 0;
    for (int j = 0; j < N; j++) begin
      if (c[j] > (1 << CW) - 1) c[j] = (1 << CW) - 1;
      if (c[j] > best) best = c[j];
    end
    idx = -1; nbest = 0;
    for (int j = 0; j < N; j++) if (c[j] == best) begin
      nbest++;
      if (idx < 0) idx = j;
    end
    cnt = best;
    t = (best > 0 && nbest > 1) ? 1 : 0;
  endtask

  task automatic run_window(input string nm, input int hold, input int e_idx, input int e_cnt, input int e_tie);
    int L, n, exp_inh;
    L = sp_q.size();
    @(negedge clk); start = 1'b1; en = 1'b1; spikes = '0; result_ready = 1'b0;
    @(negedge clk); start = 1'b0; n = 1;
    check(nm, "busy", 32'(busy), 1);
    for (int i = 0; i < L; i++) begin
      en = en_q[i]; spikes = sp_q[i];
      exp_inh = (i > 0 && INH_ON && en_q[i-1] && (|sp_q[i-1])) ? 1 : 0;
      check(nm, "inh", 32'(inh), exp_inh);
      @(negedge clk); n++;
    end
    check(nm, "inh_scan", 32'(inh), 0);
    if (hold == 0) result_ready = 1'b1;
    while (!result_valid && n < L + 40) begin
      en = 1'($urandom); spikes = N'($urandom);
      @(negedge clk); n++;
    end
    en = 1'b0; spikes = '0;
    check(nm, "latency", n, L + N + 1);
    check(nm, "idx", 32'(winner_idx), e_idx);
    check(nm, "cnt", 32'(winner_cnt), e_cnt);
    check(nm, "tie", 32'(tie), e_tie);
    for (int h = 0; h < hold; h++) begin
      start = (h % 2 == 0);
      @(negedge clk);
      check(nm, "hold_valid", 32'(result_valid), 1);
      check(nm, "hold_cnt", 32'(winner_cnt), e_cnt);
      check(nm, "hold_idx", 32'(winner_idx), e_idx);
    end
    start = 1'b0; result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    check(nm, "valid_drop", 32'(result_valid), 0);
    check(nm, "idle_busy", 32'(busy), 0);
    check(nm, "kept_cnt", 32'(winner_cnt), e_cnt);
  endtask

  initial begin
    int m_idx, m_cnt, m_tie;
    rst = 1'b1; en = 1'b0; start = 1'b0; spikes = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "busy", 32'(busy), 0);
    check("reset", "valid", 32'(result_valid), 0);
    check("reset", "idx", 32'(winner_idx), 0);
    check("reset", "cnt", 32'(winner_cnt), 0);
    check("reset", "tie", 32'(tie), 0);
    check("reset", "inh", 32'(inh), 0);
    rst = 1'b0;

    //           c0  c1  c2 c3 gap hold idx cnt tie
    vecs[0] = '{ 0,  3,  5, 0, 0,  0,   2,  5,  0};
    vecs[1] = '{ 2,  4,  1, 4, 0,  2,   1,  4,  1};
    vecs[2] = '{ 0,  0,  0, 0, 0,  1,   0,  0,  0};
    vecs[3] = '{10,  0,  0, 0, 0,  0,   0,  7,  0};
    vecs[4] = '{ 2,  0,  0, 6, 3,  5,   3,  6,  0};
    vecs[5] = '{ 9,  0, 10, 0, 1,  0,   0,  7,  1};
    for (int v = 0; v < 6; v++) begin
      build_counts(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3, vecs[v].gap);
      run_window($sformatf("vec%0d", v), vecs[v].hold, vecs[v].e_idx, vecs[v].e_cnt, vecs[v].e_tie);
    end

    // Neuron 0 spikes on window cycles 2, 3 and 7.
    sp_q.delete(); en_q.delete();
    for (int i = 1; i <= TW; i++) begin
      sp_q.push_back((i == 2 || i == 3 || i == 7) ? 4'b0001 : 4'b0000);
      en_q.push_back(1'b1);
    end
    run_window("inh_seq", 0, 0, 3, 0);

    // Reset in the middle of a window, then a clean window from zero.
    build_counts(10, 10, 10, 10, 0);
    @(negedge clk); start = 1'b1; en = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin spikes = '1; @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    check("midrst", "busy", 32'(busy), 0);
    check("midrst", "valid", 32'(result_valid), 0);
    check("midrst", "idx", 32'(winner_idx), 0);
    check("midrst", "cnt", 32'(winner_cnt), 0);
    check("midrst", "tie", 32'(tie), 0);
    check("midrst", "inh", 32'(inh), 0);
    rst = 1'b0; spikes = '0;
    build_counts(1, 0, 2, 0, 0);
    run_window("post_rst", 0, 2, 2, 0);

    for (int r = 0; r < 12; r++) begin
      build_random();
      model(m_idx, m_cnt, m_tie);
      run_window($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), m_idx, m_cnt, m_tie);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_readout.md
# spike_readout

Output decoder for the spiking network. It observes the `out_spike` lines of `N_NEURON` excitatory neurons over a fixed encoding window and counts spikes per neuron. It then selects the winning neuron (the classification result) and presents it on a valid/ready handshake to downstream logic. It can also drive the shared `inh` line back into the neuron array for lateral inhibition.

## Interface
Parameters:
- `N_NEURON`, 4: number of monitored neurons.
- `IDX_W`, 2: width of winner index; must satisfy 2^IDX_W >= N_NEURON.
- `CNT_W`, 8: width of each per-neuron spike counter.
- `T_WINDOW`, 250: window length in enabled cycles; range 1..65535.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global enable, same signal that drives the neurons.
- `start` in 1: single-cycle request to begin a window.
- `spikes` in N_NEURON: bit i is `out_spike` of neuron i.
- `result_ready` in 1: downstream accepts result.
- `busy` out 1: high in any state except IDLE.
- `result_valid` out 1: result available.
- `winner_idx` out IDX_W: index of neuron with highest count.
- `winner_cnt` out CNT_W: spike count of winner.
- `tie` out 1: another neuron equals `winner_cnt` and `winner_cnt` is nonzero.
- `inh` out 1: lateral inhibition pulse to all neurons.

## Operation
- States: IDLE, COLLECT, SCAN, DONE.
- IDLE: `start`=1 clears all counters and the window counter, then moves to COLLECT. `start` in any other state is ignored.
- COLLECT: on each cycle with `en`=1, counter i increments if `spikes[i]`=1. Counters saturate at 2^CNT_W-1 and do not wrap. The window counter increments on each cycle with `en`=1. After the T_WINDOW-th enabled cycle, the state moves to SCAN. With `en`=0, nothing changes: spikes are ignored and the window is paused.
- SCAN: one neuron is compared per cycle, index 0 to N_NEURON-1, for N_NEURON cycles, independent of `en`.
  - The running max starts at counter 0, index 0.
  - A strictly greater count replaces the max and clears `tie`.
  - An equal nonzero count sets `tie`.
  - The lowest index wins ties.
- DONE: `result_valid`=1. `winner_idx`, `winner_cnt` and `tie` stay stable until `result_valid`=1 and `result_ready`=1 at the same edge. The state then returns to IDLE and `result_valid` drops on the next cycle.
- All counts zero: `winner_idx`=0, `winner_cnt`=0, `tie`=0, and the result is still delivered.
- Result outputs keep their last value in IDLE; new values appear only when DONE is entered.
- `rst` in any state, including mid-window: state goes to IDLE and all counters, outputs and `inh` go to 0 at the next edge.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `winner_idx`=0, `winner_cnt`=0, `tie`=0, `inh`=0.
- `start` sampled at edge k: `busy`=1 from k+1. Spikes are sampled at edges k+1 through k+T_WINDOW when `en` is held high.
- SCAN occupies the next N_NEURON cycles. `result_valid` rises T_WINDOW+N_NEURON+1 cycles after the `start` edge when `en` is continuously high; each `en`-low cycle during COLLECT adds one cycle.
- Handshake: `result_ready` may be held high in advance, which gives a minimum DONE dwell of 1 cycle. A new `start` is accepted no earlier than the cycle after the handshake completes.
- A spike on the same cycle the window closes (the T_WINDOW-th enabled cycle) is counted.

## Configuration
- `SPIKE_READOUT_LATERAL_INH_EN` defined:
  - In COLLECT, `inh` pulses high for exactly one cycle, on the cycle after any enabled cycle with at least one `spikes` bit set.
  - Back-to-back spiking cycles produce back-to-back `inh` cycles.
  - `inh`=0 in all other states.
- Macro undefined: `inh` is tied to 0 and no inhibition logic is synthesized. All other behaviour is identical.

## Test plan
- T_WINDOW=10, N=4, `en`=1. Neuron 2 spikes 5×, neuron 1 spikes 3×, others 0 → `winner_idx`=2, `winner_cnt`=5, `tie`=0. `result_valid` rises 15 cycles after `start`.
- Neurons 1 and 3 each spike 4×, others fewer → `winner_idx`=1, `tie`=1. No spikes at all → `winner_idx`=0, `winner_cnt`=0, `tie`=0.
- CNT_W=3, neuron 0 spikes on all 10 cycles → `winner_cnt`=7 (saturated, no wrap).
- `en` low for 3 cycles mid-window → `result_valid` is delayed by 3 cycles; spikes during `en`=0 are not counted. Hold `result_ready`=0 for 5 cycles → outputs stay stable; `start` pulses during DONE are ignored.
- Assert `rst` halfway through COLLECT → next cycle `busy`=0 and all outputs 0. A fresh `start` then runs a full window with counters starting from 0.
- Macro defined: spikes on cycles 2, 3 and 7 of the window → `inh` high on cycles 3, 4 and 8 only. Macro undefined: `inh` stays 0 throughout.
